// File: rtl/uart_tx_arbiter_if.sv
// Producer-side and uart_tx-side handshake bundle for uart_tx_arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ack;
    logic [NUM_REQ-1:0]   req_done;
    logic [7:0]           tx_din;
    logic                 tx_start;
    logic                 tx_done;

    modport master (
        output req,
        output req_data,
        output tx_done,
        input  req_ack,
        input  req_done,
        input  tx_din,
        input  tx_start
    );

    modport slave (
        input  req,
        input  req_data,
        input  tx_done,
        output req_ack,
        output req_done,
        output tx_din,
        output tx_start
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers,
// with a watchdog that abandons a grant when uart_tx never reports done.
module uart_tx_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int NUM_CLKS_PER_BIT = 16,
    parameter int TIMEOUT_CLKS     = NUM_CLKS_PER_BIT * 12
) (
    input  logic                       clk,
    input  logic                       rstn,
    uart_tx_arbiter_if.slave           bus,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CLKS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [GW-1:0]      last_q, last_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [7:0]         din_q, din_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               tout_q, tout_d;
    logic [GW-1:0]      win;

    // Scan downward so the nearest requester after last_q is written last.
    always_comb begin
        win = last_q;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (bus.req[GW'((int'(last_q) + i) % NUM_REQ)]) begin
                win = GW'((int'(last_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        grant_d = grant_q;
        din_d   = din_q;
        busy_d  = busy_q;
        ack_d   = '0;
        done_d  = '0;
        start_d = 1'b0;
        tout_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_d      = ST_LAUNCH;
                    grant_d      = win;
                    last_d       = win;
                    din_d        = bus.req_data[{win, 3'b000} +: 8];
                    ack_d[win]   = 1'b1;
                    start_d      = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (bus.tx_done) begin
                    done_d[grant_q] = 1'b1;
                    busy_d          = 1'b0;
                    state_d         = ST_IDLE;
                end else if (cnt_q == CW'(TIMEOUT_CLKS - 1)) begin
                    tout_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            grant_q <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            din_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            din_q   <= din_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            tout_q  <= tout_d;
        end
    end

    assign bus.req_ack  = ack_q;
    assign bus.req_done = done_q;
    assign bus.tx_din   = din_q;
    assign bus.tx_start = start_q;
    assign busy         = busy_q;
    assign grant_id     = grant_q;
    assign timeout_err  = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, reset and
// spurious-done sequences, then randomized traffic against a transaction model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 192;

    logic       clk;
    logic       rstn;
    logic       busy;
    logic [1:0] grant_id;
    logic       timeout_err;

    int checks   = 0;
    int failures = 0;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bif ();

    uart_tx_arbiter #(
        .NUM_REQ(N),
        .NUM_CLKS_PER_BIT(16),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bif.slave),
        .busy(busy),
        .grant_id(grant_id),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [3:0]  req;
        logic [31:0] data;
        int          lat;
        bit          spur;
        int          gid;
        logic [7:0]  din;
    } vec_t;

    vec_t vt[15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_ack", 32'(bif.req_ack), 0);
        chk("rst_done", 32'(bif.req_done), 0);
        chk("rst_din", 32'(bif.tx_din), 0);
        chk("rst_start", 32'(bif.tx_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_tout", 32'(timeout_err), 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bif.req = '0;
        bif.tx_done = 1'b0;
        step();
        chk_reset();
        rstn = 1'b1;
    endtask

    task automatic run_vec(vec_t v);
        logic [3:0] oh;
        if (v.rst) do_reset();
        oh = 4'(1 << v.gid);
        bif.req = v.req;
        bif.req_data = v.data;
        bif.tx_done = v.spur;
        step();
        chk("v_ack", 32'(bif.req_ack), 32'(oh));
        chk("v_start", 32'(bif.tx_start), 1);
        chk("v_din", 32'(bif.tx_din), 32'(v.din));
        chk("v_gid", 32'(grant_id), 32'(v.gid));
        chk("v_busy", 32'(busy), 1);
        bif.req = '0;
        bif.req_data = ~v.data;
        bif.tx_done = v.spur;
        for (int k = 1; k <= TO + 1; k++) begin
            step();
            if (v.lat != 0 && k == v.lat + 1) begin
                chk("v_done", 32'(bif.req_done), 32'(oh));
                chk("v_done_busy", 32'(busy), 0);
                chk("v_done_tout", 32'(timeout_err), 0);
                chk("v_done_din", 32'(bif.tx_din), 32'(v.din));
                bif.tx_done = 1'b0;
                return;
            end
            if (v.lat == 0 && k == TO + 1) begin
                chk("v_tout", 32'(timeout_err), 1);
                chk("v_tout_done", 32'(bif.req_done), 0);
                chk("v_tout_busy", 32'(busy), 0);
                return;
            end
            chk("v_quiet", {busy, bif.tx_start, timeout_err,
                            |bif.req_done, |bif.req_ack, bif.tx_din},
                {5'b10000, v.din});
            bif.tx_done = (k == v.lat);
        end
        chk("v_no_end", 1, 0);
    endtask

    function automatic int rr(int last, logic [3:0] r);
        for (int off = 1; off <= N; off++) begin
            if (r[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    task automatic reset_mid_wait();
        int c;
        do_reset();
        bif.req = 4'b0010;
        bif.req_data = 32'h0000_5A00;
        step();
        c = 1;
        chk("mw_ack", 32'(bif.req_ack), 32'b0010);
        bif.req = '0;
        while (c < 50) begin
            step();
            c++;
        end
        chk("mw_busy50", 32'(busy), 1);
        rstn = 1'b0;
        step();
        c++;
        chk_reset();
        rstn = 1'b1;
        while (c < 60) begin
            step();
            c++;
        end
        bif.tx_done = 1'b1;
        step();
        chk("mw_late_done", 32'(bif.req_done), 0);
        chk("mw_late_busy", 32'(busy), 0);
        bif.tx_done = 1'b0;
        bif.req = 4'b1010;
        bif.req_data = 32'h7700_6600;
        step();
        chk("mw_gid", 32'(grant_id), 1);
        chk("mw_ack2", 32'(bif.req_ack), 32'b0010);
        chk("mw_din", 32'(bif.tx_din), 32'h66);
        bif.req = '0;
        step();
        bif.tx_done = 1'b1;
        step();
        chk("mw_done2", 32'(bif.req_done), 32'b0010);
        bif.tx_done = 1'b0;
    endtask

    task automatic random_run(int ncyc);
        bit         m_act;
        int         m_gc, m_last, m_lat, win, sel;
        logic [3:0] e_ack, e_done, pa;
        logic [7:0] e_din;
        logic [1:0] e_gid;
        bit         e_start, e_busy, e_to;
        do_reset();
        m_act = 0; m_gc = 0; m_last = N - 1; m_lat = 0;
        e_ack = 0; e_done = 0; pa = 0; e_din = 0; e_gid = 0;
        e_start = 0; e_busy = 0; e_to = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            if (cyc > 0) begin
                chk("r_ack", 32'(bif.req_ack), 32'(e_ack));
                chk("r_done", 32'(bif.req_done), 32'(e_done));
                chk("r_start", 32'(bif.tx_start), 32'(e_start));
                chk("r_din", 32'(bif.tx_din), 32'(e_din));
                chk("r_busy", 32'(busy), 32'(e_busy));
                chk("r_gid", 32'(grant_id), 32'(e_gid));
                chk("r_tout", 32'(timeout_err), 32'(e_to));
            end
            for (int i = 0; i < N; i++) begin
                if (pa[i]) begin
                    bif.req[i] = 1'($urandom_range(0, 1));
                    bif.req_data[8*i +: 8] = 8'($urandom);
                end else if (!bif.req[i]) begin
                    bif.req_data[8*i +: 8] = 8'($urandom);
                    if ($urandom_range(0, 7) == 0) bif.req[i] = 1'b1;
                end
            end
            pa = e_ack;
            if (m_act && m_lat != 0 && cyc == m_gc + 1 + m_lat)
                bif.tx_done = 1'b1;
            else if ((!m_act || cyc == m_gc + 1) && $urandom_range(0, 9) == 0)
                bif.tx_done = 1'b1;
            else
                bif.tx_done = 1'b0;
            e_ack = 0; e_done = 0; e_start = 0; e_to = 0;
            if (!m_act) begin
                if (|bif.req) begin
                    win = rr(m_last, bif.req);
                    m_last = win;
                    e_gid = 2'(win);
                    e_din = bif.req_data[8*win +: 8];
                    e_ack[win] = 1'b1;
                    e_start = 1;
                    m_act = 1;
                    m_gc = cyc;
                    sel = $urandom_range(0, 99);
                    if (sel < 80) m_lat = $urandom_range(1, 40);
                    else if (sel < 92) m_lat = $urandom_range(150, TO);
                    else if (sel < 96) m_lat = TO;
                    else m_lat = 0;
                end
            end else if (cyc >= m_gc + 2) begin
                if (bif.tx_done) begin
                    e_done[e_gid] = 1'b1;
                    m_act = 0;
                end else if (cyc == m_gc + 1 + TO) begin
                    e_to = 1;
                    m_act = 0;
                end
            end
            e_busy = m_act;
            step();
        end
        bif.req = '0;
        bif.tx_done = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        bif.req = '0;
        bif.req_data = '0;
        bif.tx_done = 1'b0;

        vt[0]  = '{1, 4'b1111, 32'h1312_1110,   5, 0, 0, 8'h10};
        vt[1]  = '{0, 4'b1111, 32'h1312_1110,   7, 0, 1, 8'h11};
        vt[2]  = '{0, 4'b1111, 32'h1312_1110,   3, 1, 2, 8'h12};
        vt[3]  = '{0, 4'b1111, 32'h1312_1110,   1, 0, 3, 8'h13};
        vt[4]  = '{0, 4'b1111, 32'h1312_1110,   9, 0, 0, 8'h10};
        vt[5]  = '{1, 4'b0101, 32'h0033_0011,   4, 0, 0, 8'h11};
        vt[6]  = '{0, 4'b0101, 32'h0033_0011,   4, 0, 2, 8'h33};
        vt[7]  = '{0, 4'b0001, 32'h0033_0011,   4, 0, 0, 8'h11};
        vt[8]  = '{0, 4'b0001, 32'h0033_0011,   4, 0, 0, 8'h11};
        vt[9]  = '{1, 4'b0100, 32'h00A5_0000, 160, 0, 2, 8'hA5};
        vt[10] = '{0, 4'b0010, 32'h0000_BB00,   0, 0, 1, 8'hBB};
        vt[11] = '{0, 4'b0110, 32'h00CC_DD00,   2, 1, 2, 8'hCC};
        vt[12] = '{0, 4'b1000, 32'hEE00_0000,  TO, 0, 3, 8'hEE};
        vt[13] = '{0, 4'b1011, 32'h4433_2211,   0, 0, 0, 8'h11};
        vt[14] = '{0, 4'b1011, 32'h4433_2211,   2, 1, 1, 8'h22};

        step();
        do_reset();
        for (int i = 0; i < 15; i++) run_vec(vt[i]);
        reset_mid_wait();
        random_run(20000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter between NUM_REQ byte producers using round-robin arbitration.
- Latches the winner's byte, drives the uart_tx start/din handshake, and waits for done.
- Returns per-requester ack (byte consumed) and done (byte on the wire) pulses.
- A watchdog aborts a grant if uart_tx never reports done. Sits between producer logic and uart_tx on the tx clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NUM_CLKS_PER_BIT, 16, uart_tx bit period in clocks; used only for the default timeout
TIMEOUT_CLKS, NUM_CLKS_PER_BIT*12, clocks allowed in WAIT before timeout (>=2)

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
req  input  NUM_REQ  per-requester byte request; held with data until ack
req_data  input  NUM_REQ*8  byte of requester i at bits [8i+7:8i]
req_ack  output  NUM_REQ  one-hot 1-cycle pulse: byte latched
req_done  output  NUM_REQ  one-hot 1-cycle pulse: uart_tx reported done for that byte
tx_din  output  8  byte to uart_tx; stable from launch until return to IDLE
tx_start  output  1  1-cycle start pulse to uart_tx
tx_done  input  1  done pulse from uart_tx
busy  output  1  high in LAUNCH and WAIT
grant_id  output  $clog2(NUM_REQ)  index of current or last grant
timeout_err  output  1  1-cycle pulse on watchdog abort

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rstn. All outputs are registered.
- Reset values: req_ack=0, req_done=0, tx_din=0, tx_start=0, busy=0, grant_id=0, timeout_err=0, state=IDLE, wait counter=0, last_grant=NUM_REQ-1 (so req[0] has first priority).
- States: IDLE, LAUNCH, WAIT.
- IDLE, no req: stay in IDLE.
- IDLE, any req=1 in cycle T:
  - Winner = first set bit scanning from (last_grant+1) mod NUM_REQ upward, wrapping.
  - At the edge ending T: state<=LAUNCH, grant_id<=winner, last_grant<=winner, tx_din<=req_data[winner], req_ack[winner]<=1, tx_start<=1, busy<=1.
  - So req_ack and tx_start are both visible in cycle T+1.
- LAUNCH (cycle T+1): at the edge, state<=WAIT, tx_start<=0, req_ack<=0, counter<=0. tx_done is ignored in LAUNCH.
- WAIT:
  - tx_done=1: req_done[grant_id] pulses the next cycle, busy<=0, state<=IDLE.
  - Else if counter==TIMEOUT_CLKS-1: timeout_err pulses the next cycle, busy<=0, state<=IDLE, no req_done.
  - Else counter increments.
  - tx_done takes priority over timeout in the same cycle.
- Back-to-back: IDLE is occupied for at least one cycle between grants. With tx_done in cycle D, the next arbitration happens in D+1 and the next tx_start appears in D+2.
- req is sampled only in IDLE. Requests raised or dropped during LAUNCH/WAIT have no effect. A requester may drop or reassert req in the cycle after its ack.
- req_data is sampled only on the granting edge; later changes do not alter tx_din.
- tx_done is ignored in IDLE and LAUNCH (stale or late pulses are harmless).
- Round-robin pointer advances on grant, not on completion. A timed-out grant still consumes the requester's turn and is not retried.
- Reset mid-operation: all state and outputs return to reset values at the reset edge. No req_done or timeout_err is issued for the aborted byte. uart_tx is reset separately.
- Counter width: $clog2(TIMEOUT_CLKS); counter never exceeds TIMEOUT_CLKS-1.

Test Plan:
- Single request: req=4'b0100, req_data[23:16]=8'hA5 in cycle 0.
  -> Cycle 1: req_ack=4'b0100, tx_start=1, tx_din=8'hA5, grant_id=2.
  -> Model tx_done 160 clocks after start: req_done=4'b0100 the next cycle; busy low the same cycle.
- All four request together, each re-requesting after ack, data 8'h10..8'h13.
  -> Grants in order 0,1,2,3,0.
  -> tx_din sequence 10,11,12,13,10; exactly one tx_start per byte.
- Fairness: req[0] held high continuously, req[2] raised once.
  -> Grants 0,2,0,0; req[2] is never starved beyond one grant of req[0].
- Timeout: TIMEOUT_CLKS=192, tx_done tied low, req[1] in cycle 0.
  -> timeout_err pulses in cycle 194; no req_done; busy=0 in cycle 194.
  -> Next request in cycle 194 is granted to index 2 if pending, else to 1.
- Reset mid-WAIT: rstn=0 for one cycle at cycle 50 of a transfer.
  -> At cycle 51 all outputs are 0 and state is IDLE.
  -> Late tx_done at cycle 60 produces no req_done.
  -> First grant after reset goes to the lowest pending index.
- Spurious done: tx_done pulsed in IDLE and in the LAUNCH cycle.
  -> No req_done.
  -> A real tx_done later in WAIT completes normally.
